parity_frame_rx: RTL and testbench

// Serial receiver and checker for parity-protected frames.

---
 rtl/parity_frame_rx.sv | 147 ++++++++++++++
 tb/tb_parity_frame_rx.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/parity_frame_rx.sv
// parity_frame_rx: serial receiver for start/data/parity/stop frames.
// Deserialises DATA_W data bits (LSB first), checks parity, flags a bad stop
// bit, and presents the word together with its AND/OR/XOR reductions.
// Frames stalled for TIMEOUT cycles are dropped with a one-cycle abort pulse.
module parity_frame_rx #(
  parameter int DATA_W     = 4,
  parameter bit PARITY_ODD = 1'b0,
  parameter int TIMEOUT    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              in_bit,
  output logic              busy,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              and_out,
  output logic              or_out,
  output logic              xor_out,
  output logic              parity_err,
  output logic              frame_err,
  output logic              abort
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  // A zero-width counter is illegal, so keep one bit when the timeout is disabled.
  localparam int TO_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic                par_q, par_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                parity_err_q, parity_err_d;
  logic                frame_err_q, frame_err_d;
  logic                out_valid_q, out_valid_d;
  logic                abort_q, abort_d;
  logic [DATA_W:0]     shift_in;

  // New bit enters at the top; after DATA_W shifts the first bit sits at bit 0.
  assign shift_in = {in_bit, shift_q};

  // Next-state, datapath and timeout logic.
  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path leaves it
    // unassigned and no latch is inferred.
    state_d      = state_q;
    cnt_d        = cnt_q;
    to_cnt_d     = to_cnt_q;
    shift_d      = shift_q;
    par_d        = par_q;
    out_data_d   = out_data_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    out_valid_d  = 1'b0;
    abort_d      = 1'b0;

    if (in_valid) begin
      unique case (state_q)
        S_IDLE: begin
          if (!in_bit) begin
            state_d = S_DATA;
            cnt_d   = '0;
          end
        end
        S_DATA: begin
          shift_d = shift_in[DATA_W:1];
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(DATA_W - 1)) state_d = S_PARITY;
        end
        S_PARITY: begin
          par_d   = in_bit;
          state_d = S_STOP;
        end
        S_STOP: begin
          state_d      = S_IDLE;
          out_data_d   = shift_q;
          parity_err_d = par_q ^ (^shift_q) ^ PARITY_ODD;
          frame_err_d  = ~in_bit;
          out_valid_d  = 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (TIMEOUT > 0) begin
      if (in_valid || state_q == S_IDLE) begin
        to_cnt_d = '0;
      end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
        // Stalled for the full timeout: drop the frame, results stay untouched.
        to_cnt_d = '0;
        state_d  = S_IDLE;
        abort_d  = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end
  end

  // State and result registers; reset discards any partial frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      to_cnt_q     <= '0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      out_data_q   <= '0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      out_valid_q  <= 1'b0;
      abort_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge
      // values, independent of statement order.
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      to_cnt_q     <= to_cnt_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      out_data_q   <= out_data_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      out_valid_q  <= out_valid_d;
      abort_q      <= abort_d;
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign and_out    = &out_data_q;
  assign or_out     = |out_data_q;
  assign xor_out    = ^out_data_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign abort      = abort_q;

endmodule

// File: tb/tb_parity_frame_rx.sv
// Directed bench for parity_frame_rx (DATA_W=4, even parity, TIMEOUT=16).
module tb_parity_frame_rx;

  localparam int DATA_W = 4;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_bit;
  logic              busy;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              and_out;
  logic              or_out;
  logic              xor_out;
  logic              parity_err;
  logic              frame_err;
  logic              abort;

  int total;
  int passed;

  parity_frame_rx #(.DATA_W(4), .PARITY_ODD(1'b0), .TIMEOUT(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_bit     (in_bit),
    .busy       (busy),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .and_out    (and_out),
    .or_out     (or_out),
    .xor_out    (xor_out),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .abort      (abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed bundle: {busy, out_valid, out_data, and, or, xor, parity_err, frame_err, abort}
  function automatic logic [11:0] obs();
    return {busy, out_valid, out_data, and_out, or_out, xor_out, parity_err, frame_err, abort};
  endfunction

  // One valid bit; returns 1 time unit after the sampling edge with in_valid low.
  task automatic send_bit(input logic b);
    in_valid = 1'b1;
    in_bit   = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_bit   = 1'b1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Start, data LSB first, parity, stop, with `gap` stall cycles between bits.
  task automatic send_frame(input logic [DATA_W-1:0] d, input logic p, input logic s,
                            input int gap);
    send_bit(1'b0);
    for (int i = 0; i < DATA_W; i++) begin
      idle_cycles(gap);
      send_bit(d[i]);
    end
    idle_cycles(gap);
    send_bit(p);
    idle_cycles(gap);
    send_bit(s);
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_bit   = 1'b1;
    idle_cycles(3);
    total++;
    if (obs() !== 12'b0) $display("FAIL reset_in: got %b want %b", obs(), 12'b0);
    else passed++;
    rst_n = 1'b1;
    idle_cycles(2);
    total++;
    if (obs() !== 12'b0) $display("FAIL reset_after: got %b want %b", obs(), 12'b0);
    else passed++;
  endtask

  // Case 1: word 1010, good parity and stop.
  task automatic test_basic();
    send_bit(1'b0);
    total++;
    if (busy !== 1'b1) $display("FAIL basic_busy: got %b want 1", busy);
    else passed++;
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    send_bit(1'b0);
    total++;
    if (out_valid !== 1'b0) $display("FAIL basic_early_valid: got %b want 0", out_valid);
    else passed++;
    send_bit(1'b1);
    total++;
    if (obs() !== 12'b0_1_1010_010_00_0)
      $display("FAIL basic_result: got %b want %b", obs(), 12'b0_1_1010_010_00_0);
    else passed++;
    idle_cycles(1);
    total++;
    if (obs() !== 12'b0_0_1010_010_00_0)
      $display("FAIL basic_hold: got %b want %b", obs(), 12'b0_0_1010_010_00_0);
    else passed++;
  endtask

  // Case 2: word 1101 with parity 0 -> parity error.
  task automatic test_parity_err();
    send_frame(4'b1101, 1'b0, 1'b1, 0);
    total++;
    if (obs() !== 12'b0_1_1101_011_10_0)
      $display("FAIL parity_err: got %b want %b", obs(), 12'b0_1_1101_011_10_0);
    else passed++;
  endtask

  // Case 3: word 1111, stop sampled 0 -> frame error.
  task automatic test_frame_err();
    send_frame(4'b1111, 1'b0, 1'b0, 0);
    total++;
    if (obs() !== 12'b0_1_1111_110_01_0)
      $display("FAIL frame_err: got %b want %b", obs(), 12'b0_1_1111_110_01_0);
    else passed++;
    idle_cycles(1);
  endtask

  // Case 4: stalls between bits, then timeout abort, then recovery.
  task automatic test_stall_timeout();
    send_frame(4'b1010, 1'b0, 1'b1, 5);
    total++;
    if (obs() !== 12'b0_1_1010_010_00_0)
      $display("FAIL stall_result: got %b want %b", obs(), 12'b0_1_1010_010_00_0);
    else passed++;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    idle_cycles(15);
    total++;
    if ({busy, abort} !== 2'b10)
      $display("FAIL timeout_15: got busy/abort %b want 10", {busy, abort});
    else passed++;
    idle_cycles(1);
    total++;
    if (obs() !== 12'b0_0_1010_010_00_1)
      $display("FAIL timeout_abort: got %b want %b", obs(), 12'b0_0_1010_010_00_1);
    else passed++;
    idle_cycles(1);
    total++;
    if (abort !== 1'b0) $display("FAIL abort_pulse: got %b want 0", abort);
    else passed++;
    send_frame(4'b0110, 1'b0, 1'b1, 0);
    total++;
    if (obs() !== 12'b0_1_0110_010_00_0)
      $display("FAIL after_abort: got %b want %b", obs(), 12'b0_1_0110_010_00_0);
    else passed++;
  endtask

  // Case 5: asynchronous reset mid-DATA.
  task automatic test_reset_mid();
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (obs() !== 12'b0) $display("FAIL reset_mid: got %b want %b", obs(), 12'b0);
    else passed++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle_cycles(1);
    send_frame(4'b1001, 1'b0, 1'b1, 0);
    total++;
    if (obs() !== 12'b0_1_1001_010_00_0)
      $display("FAIL reset_recover: got %b want %b", obs(), 12'b0_1_1001_010_00_0);
    else passed++;
  endtask

  // Case 6: long idle line, then two frames with no gap.
  task automatic test_back_to_back();
    int bad;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      send_bit(1'b1);
      total++;
      if ({busy, out_valid, abort} !== 3'b000) begin
        $display("FAIL idle_line[%0d]: got %b want 000", i, {busy, out_valid, abort});
        bad++;
      end else passed++;
    end
    send_frame(4'b0000, 1'b0, 1'b1, 0);
    total++;
    if (obs() !== 12'b0_1_0000_000_00_0)
      $display("FAIL b2b_first: got %b want %b", obs(), 12'b0_1_0000_000_00_0);
    else passed++;
    send_bit(1'b0);
    total++;
    if ({busy, out_valid, out_data} !== 6'b1_0_0000)
      $display("FAIL b2b_start: got %b want %b", {busy, out_valid, out_data}, 6'b100000);
    else passed++;
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    total++;
    if (obs() !== 12'b0_1_1111_110_00_0)
      $display("FAIL b2b_second: got %b want %b", obs(), 12'b0_1_1111_110_00_0);
    else passed++;
    idle_cycles(1);
    total++;
    if (out_valid !== 1'b0) $display("FAIL b2b_pulse: got %b want 0", out_valid);
    else passed++;
  endtask

  initial begin
    total  = 0;
    passed = 0;
    test_reset();
    test_basic();
    test_parity_err();
    test_frame_err();
    test_stall_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
